// File: rtl/wavetable_pkg.sv
// Shared constants and state encoding for the wavetable oscillator reader and its helpers.
package wavetable_pkg;

    localparam int unsigned PHASE_W     = 32;
    localparam int unsigned ADDR_W      = 9;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned FRAC_W      = 8;
    localparam int unsigned TABLE_DEPTH = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH1 = 2'd1,
        CAP1   = 2'd2,
        MULT   = 2'd3
    } state_t;

endpackage

// File: rtl/wavetable_osc_reader_lerp_sat.sv
// Linear interpolation between two signed table words, floored and saturated to DATA_W.
module lerp_sat
    import wavetable_pkg::*;
(
    input  logic [DATA_W-1:0] s0,
    input  logic [DATA_W-1:0] s1,
    input  logic [FRAC_W-1:0] frac,
    output logic [DATA_W-1:0] y
);

    localparam int unsigned PW = DATA_W + FRAC_W + 2;
    localparam logic signed [PW-1:0] MAX_V = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] MIN_V = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W:0] d;
    logic signed [FRAC_W:0] frac_s;
    logic signed [PW-1:0]   p;
    logic signed [PW-1:0]   sum;

    // Arithmetic shift floors the scaled difference toward minus infinity.
    always_comb begin
        d      = {s1[DATA_W-1], s1} - {s0[DATA_W-1], s0};
        frac_s = {1'b0, frac};
        p      = PW'(d) * PW'(frac_s);
        sum    = PW'($signed(s0)) + (p >>> FRAC_W);
        if (sum > MAX_V) begin
            y = MAX_V[DATA_W-1:0];
        end else if (sum < MIN_V) begin
            y = MIN_V[DATA_W-1:0];
        end else begin
            y = sum[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/wavetable_osc_reader.sv
// Phase-accumulator oscillator reading a synchronous sine ROM and emitting
// one interpolated sample per accepted tick over a valid/ready handshake.
module wavetable_osc_reader
    import wavetable_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               enable,
    input  logic               sample_tick,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic               phase_reset,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [DATA_W-1:0]  rom_q,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               overrun
);

    state_t              state;
    state_t              state_next;
    logic [PHASE_W-1:0]  phase;
    logic [ADDR_W-1:0]   idx;
    logic [FRAC_W-1:0]   frac;
    logic [DATA_W-1:0]   s0;
    logic [DATA_W-1:0]   s1;
    logic [DATA_W-1:0]   y;
    logic                out_pending;
    logic                tick_en_c;
    logic                accept_c;
    logic                drop_c;

    assign tick_en_c = sample_tick & enable;
    assign accept_c  = tick_en_c & (state == IDLE) & ~(sample_valid & ~sample_ready);
    assign drop_c    = tick_en_c & ~accept_c;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = FETCH1;
            FETCH1:  state_next = CAP1;
            CAP1:    state_next = MULT;
            MULT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ROM words arrive one cycle after their address: s0 lands in CAP1, s1 in MULT.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            phase        <= '0;
            idx          <= '0;
            frac         <= '0;
            s0           <= '0;
            s1           <= '0;
            rom_address  <= '0;
            out_pending  <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun     <= drop_c;
            out_pending <= (state == MULT);

            // Dropped ticks still advance the phase so pitch is preserved.
            if (phase_reset) begin
                phase <= '0;
            end else if (tick_en_c) begin
                phase <= phase + phase_inc;
            end

            if (accept_c) begin
                idx         <= phase[PHASE_W-1 -: ADDR_W];
                frac        <= phase[PHASE_W-ADDR_W-1 -: FRAC_W];
                rom_address <= phase[PHASE_W-1 -: ADDR_W];
            end else if (state == FETCH1) begin
                rom_address <= idx + ADDR_W'(1);
            end

            if (state == CAP1) begin
                s0 <= rom_q;
            end
            if (state == MULT) begin
                s1 <= rom_q;
            end

            if (out_pending) begin
                sample_out   <= y;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

    lerp_sat u_lerp (
        .s0   (s0),
        .s1   (s1),
        .frac (frac),
        .y    (y)
    );

endmodule
